// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-path types and default widths for the read arbiter slice.
//   AXI_*WIDTH : default address/data/length/id widths of the downstream port
//   size_t     : beat size field (log2 of bytes per beat)
//   burst_e    : burst type encoding
//   resp_e     : read/write response encoding
package axi_rd_arbiter_pkg;

  localparam int AXI_AWIDTH   = 32;
  localparam int AXI_DWIDTH   = 32;
  localparam int AXI_LENWIDTH = 8;
  localparam int AXI_IDWIDTH  = 4;

  typedef logic [2:0] size_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI port bundle: full AR and R channels plus the write-side valid/ready
// strobes that a read-only manager ties off.
//   master : drives AR, rready and the write-side strobes
//   slave  : drives arready and the R channel
interface axi_rd_arbiter_if;
  import axi_rd_arbiter_pkg::*;

  logic                    arvalid;
  logic                    arready;
  logic [AXI_AWIDTH-1:0]   araddr;
  logic [AXI_LENWIDTH-1:0] arlen;
  size_t                   arsize;
  burst_e                  arburst;
  logic [AXI_IDWIDTH-1:0]  arid;

  logic                    rvalid;
  logic                    rready;
  logic [AXI_DWIDTH-1:0]   rdata;
  resp_e                   rresp;
  logic                    rlast;
  logic [AXI_IDWIDTH-1:0]  rid;

  logic                    awvalid;
  logic                    wvalid;
  logic                    bready;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
           awvalid, wvalid, bready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
           awvalid, wvalid, bready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface

// File: rtl/axi_rr_pick.sv
// Combinational rotating-priority picker.
//   req_i  : request vector
//   last_i : index of the previous winner; search starts at last_i+1
//   any_o  : at least one request is set
//   idx_o  : winning index (0 when any_o is low)
// N need not be a power of two, so the pointer wrap is an explicit compare.
module axi_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = (last_i == IDX_W'(N-1)) ? '0 : last_i + IDX_W'(1);
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
      cand = (cand == IDX_W'(N-1)) ? '0 : cand + IDX_W'(1);
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port between NUM_REQ requesters.
// One burst outstanding at a time; R beats go to the owner until RLAST.
//   i_aclk, i_arst        : clock, async active-high reset
//   i_arvalid/o_arready   : per-requester AR handshake
//   i_araddr/arlen/arsize/arburst : per-requester AR payload
//   o_rvalid/i_rready     : per-requester R handshake (owner only)
//   o_rdata/o_rresp/o_rlast : R payload broadcast to all requesters
//   m_axi                 : downstream port, write side tied off
//
// state | meaning
// IDLE  | nothing driven downstream; pick next owner from pending requests
// ADDR  | owner's AR presented downstream, waiting for arready
// DATA  | R beats routed to owner until the RLAST handshake
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int AWIDTH   = AXI_AWIDTH,
  parameter int DWIDTH   = AXI_DWIDTH,
  parameter int LENWIDTH = AXI_LENWIDTH
) (
  input  logic                             i_aclk,
  input  logic                             i_arst,
  input  logic [NUM_REQ-1:0]               i_arvalid,
  output logic [NUM_REQ-1:0]               o_arready,
  input  logic [NUM_REQ-1:0][AWIDTH-1:0]   i_araddr,
  input  logic [NUM_REQ-1:0][LENWIDTH-1:0] i_arlen,
  input  size_t [NUM_REQ-1:0]              i_arsize,
  input  burst_e [NUM_REQ-1:0]             i_arburst,
  output logic [NUM_REQ-1:0]               o_rvalid,
  input  logic [NUM_REQ-1:0]               i_rready,
  output logic [DWIDTH-1:0]                o_rdata,
  output resp_e                            o_rresp,
  output logic                             o_rlast,
  axi_rd_arbiter_if.master                 m_axi
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } rd_arb_state_e;

  rd_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             ar_fire;
  logic             r_done;

  axi_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (i_arvalid),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // Payload muxes are static on grant; only the valid/ready strobes are gated by state.
  assign m_axi.araddr  = i_araddr[grant_q];
  assign m_axi.arlen   = i_arlen[grant_q];
  assign m_axi.arsize  = i_arsize[grant_q];
  assign m_axi.arburst = i_arburst[grant_q];
  assign m_axi.arid    = AXI_IDWIDTH'(grant_q);
  assign m_axi.awvalid = 1'b0;
  assign m_axi.wvalid  = 1'b0;
  assign m_axi.bready  = 1'b0;

  assign o_rdata = m_axi.rdata;
  assign o_rresp = m_axi.rresp;
  assign o_rlast = m_axi.rlast;

  assign ar_fire = i_arvalid[grant_q] & m_axi.arready;
  assign r_done  = m_axi.rvalid & i_rready[grant_q] & m_axi.rlast;

  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    o_arready     = '0;
    o_rvalid      = '0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axi.arvalid      = i_arvalid[grant_q];
        o_arready[grant_q] = m_axi.arready;
        if (ar_fire) state_d = ST_DATA;
      end
      ST_DATA: begin
        o_rvalid[grant_q] = m_axi.rvalid;
        m_axi.rready      = i_rready[grant_q];
        if (r_done) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef SYNTHESIS
  a_ar_hold: assert property (@(posedge i_aclk) disable iff (i_arst)
    (state_q == ST_ADDR) |-> i_arvalid[grant_q]);
  a_rid_match: assert property (@(posedge i_aclk) disable iff (i_arst)
    (state_q == ST_DATA && m_axi.rvalid) |-> (m_axi.rid == AXI_IDWIDTH'(grant_q)));
  a_rvalid_onehot0: assert property (@(posedge i_aclk) disable iff (i_arst)
    $onehot0(o_rvalid));
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } req_t;

  typedef struct {
    logic [31:0] data;
    resp_e       resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          i_arvalid;
  logic [N-1:0]          o_arready;
  logic [N-1:0][31:0]    i_araddr;
  logic [N-1:0][7:0]     i_arlen;
  size_t [N-1:0]         i_arsize;
  burst_e [N-1:0]        i_arburst;
  logic [N-1:0]          o_rvalid;
  logic [N-1:0]          i_rready;
  logic [31:0]           o_rdata;
  resp_e                 o_rresp;
  logic                  o_rlast;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter #(.NUM_REQ(N)) dut (
    .i_aclk    (clk),
    .i_arst    (rst),
    .i_arvalid (i_arvalid),
    .o_arready (o_arready),
    .i_araddr  (i_araddr),
    .i_arlen   (i_arlen),
    .i_arsize  (i_arsize),
    .i_arburst (i_arburst),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready),
    .o_rdata   (o_rdata),
    .o_rresp   (o_rresp),
    .o_rlast   (o_rlast),
    .m_axi     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and models
  req_t  req_q [N][$];
  beat_t exp_r [N][$];
  ar_t   exp_ar[$];

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          err_beat = -1;
  int          ar_stall = 0;
  logic [31:0] stall_addr = '0;
  bit          s_busy = 0;
  logic [3:0]  s_id = '0;
  logic [31:0] s_addr = '0;
  logic [7:0]  s_len = '0;
  int          s_beat = 0;
  bit [N-1:0]  tog = '0;
  bit          chk_gap = 0;
  int          last_any_ar = -1;
  logic        smp_m_arvalid;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_req(int r, logic [31:0] addr, logic [7:0] len, int errb);
    req_t  t;
    beat_t b;
    t.addr = addr;
    t.len  = len;
    req_q[r].push_back(t);
    for (int i = 0; i <= int'(len); i++) begin
      b.data = addr + 32'(i);
      b.resp = (i == errb) ? RESP_SLVERR : RESP_OKAY;
      b.last = (i == int'(len));
      exp_r[r].push_back(b);
    end
  endtask

  task automatic push_ar(logic [1:0] id, logic [31:0] addr, logic [7:0] len);
    ar_t a;
    a.id   = id;
    a.addr = addr;
    a.len  = len;
    exp_ar.push_back(a);
  endtask

  function automatic bit pending();
    bit p;
    p = s_busy || (exp_ar.size() != 0);
    for (int r = 0; r < N; r++)
      if (req_q[r].size() != 0 || exp_r[r].size() != 0) p = 1;
    return p;
  endfunction

  task automatic clear_models();
    for (int r = 0; r < N; r++) begin
      req_q[r].delete();
      exp_r[r].delete();
    end
    exp_ar.delete();
    s_busy   = 0;
    s_beat   = 0;
    ar_stall = 0;
  endtask

  // One clock: drive at negedge, sample 1 unit later, DUT updates at posedge.
  task automatic tick();
    beat_t eb;
    ar_t   ea;
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      if (req_q[r].size() != 0) begin
        i_arvalid[r] = 1'b1;
        i_araddr[r]  = req_q[r][0].addr;
        i_arlen[r]   = req_q[r][0].len;
      end else begin
        i_arvalid[r] = 1'b0;
        i_araddr[r]  = '0;
        i_arlen[r]   = '0;
      end
      i_rready[r] = tog[r] ? cyc[0] : 1'b1;
    end
    bus.arready = (ar_stall == 0);
    bus.rvalid  = s_busy;
    bus.rdata   = s_addr + 32'(s_beat);
    bus.rresp   = (s_busy && s_beat == err_beat) ? RESP_SLVERR : RESP_OKAY;
    bus.rlast   = s_busy && (s_beat == int'(s_len));
    bus.rid     = s_id;
    #1;
    smp_m_arvalid = bus.arvalid;
    check("rvalid_onehot0", 64'($onehot0(o_rvalid)), 1);
    if (s_busy) begin
      check("one_outstanding", bus.arvalid, 0);
      check("busy_oready", o_arready, 0);
    end
    for (int r = 0; r < N; r++) begin
      if (o_rvalid[r] && i_rready[r]) begin
        if (exp_r[r].size() == 0) check($sformatf("r%0d_unexpected", r), 1, 0);
        else begin
          eb = exp_r[r].pop_front();
          check($sformatf("r%0d_rdata", r), o_rdata, eb.data);
          check($sformatf("r%0d_rresp", r), o_rresp, eb.resp);
          check($sformatf("r%0d_rlast", r), o_rlast, eb.last);
        end
      end
      if (i_arvalid[r] && o_arready[r]) void'(req_q[r].pop_front());
    end
    if (ar_stall > 0 && bus.arvalid) begin
      check("bp_oready", o_arready, 0);
      check("bp_araddr", bus.araddr, stall_addr);
      ar_stall--;
    end
    if (bus.rvalid && bus.rready) begin
      if (s_beat == int'(s_len)) s_busy = 0;
      else s_beat++;
    end
    if (bus.arvalid && bus.arready) begin
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else begin
        ea = exp_ar.pop_front();
        check("arid", bus.arid, ea.id);
        check("araddr", bus.araddr, ea.addr);
        check("arlen", bus.arlen, ea.len);
      end
      if (chk_gap && last_any_ar >= 0) check("ar_gap", cyc - last_any_ar, 3);
      last_any_ar = cyc;
      s_busy = 1;
      s_id   = bus.arid;
      s_addr = bus.araddr;
      s_len  = bus.arlen;
      s_beat = 0;
    end
    cyc++;
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(pending()), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_arvalid = '0;
    i_rready  = '0;
    i_araddr  = '0;
    i_arlen   = '0;
    for (int r = 0; r < N; r++) begin
      i_arsize[r]  = 3'd2;
      i_arburst[r] = BURST_INCR;
    end
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = RESP_OKAY;
    bus.rlast   = 1'b0;
    bus.rid     = '0;

    // reset state
    tick();
    tick();
    check("rst_oready", o_arready, 0);
    check("rst_orvalid", o_rvalid, 0);
    check("rst_m_arvalid", bus.arvalid, 0);
    check("rst_m_rready", bus.rready, 0);
    check("rst_last", dut.last_q, 2);
    check("rst_tieoff", {bus.awvalid, bus.wvalid, bus.bready}, 0);
    rst = 1'b0;
    tick();

    // 1: single requester, 4 beats, 1-cycle AR latency
    push_req(0, 32'h100, 8'd3, -1);
    push_ar(2'd0, 32'h100, 8'd3);
    tick();
    check("t1_lat_cycle0", smp_m_arvalid, 0);
    tick();
    check("t1_lat_cycle1", smp_m_arvalid, 1);
    drain("t1", 30);
    tick();
    check("t1_idle_rready", bus.rready, 0);
    check("t1_idle_arvalid", bus.arvalid, 0);

    // 2: contention, last=0 so requester 1 leads, then strict alternation
    chk_gap = 1;
    last_any_ar = -1;
    push_req(0, 32'h200, 8'd0, -1);
    push_req(0, 32'h210, 8'd0, -1);
    push_req(1, 32'h300, 8'd0, -1);
    push_req(1, 32'h310, 8'd0, -1);
    push_ar(2'd1, 32'h300, 8'd0);
    push_ar(2'd0, 32'h200, 8'd0);
    push_ar(2'd1, 32'h310, 8'd0);
    push_ar(2'd0, 32'h210, 8'd0);
    drain("t2", 40);
    chk_gap = 0;

    // 3: AR backpressure for 5 cycles, requester toggles rready
    ar_stall   = 5;
    stall_addr = 32'h400;
    tog[0]     = 1'b1;
    push_req(0, 32'h400, 8'd3, -1);
    push_ar(2'd0, 32'h400, 8'd3);
    drain("t3", 40);
    check("t3_stall_seen", 64'(ar_stall), 0);
    tog[0] = 1'b0;

    // 4: SLVERR on beat 2 of 4, grant held until RLAST
    err_beat = 1;
    push_req(1, 32'h500, 8'd3, 1);
    push_req(0, 32'h600, 8'd0, -1);
    push_ar(2'd1, 32'h500, 8'd3);
    push_ar(2'd0, 32'h600, 8'd0);
    drain("t4", 40);
    err_beat = -1;

    // 5: reset in the middle of an 8-beat burst
    push_req(1, 32'h700, 8'd7, -1);
    push_ar(2'd1, 32'h700, 8'd7);
    n = 0;
    while (!s_busy && n < 10) begin
      tick();
      n++;
    end
    check("t5_started", 64'(s_busy), 1);
    tick();
    check("t5_mid_rvalid", o_rvalid, 3'b010);
    rst = 1'b1;
    #1;
    check("t5_rst_orvalid", o_rvalid, 0);
    check("t5_rst_oready", o_arready, 0);
    check("t5_rst_m_arvalid", bus.arvalid, 0);
    check("t5_rst_m_rready", bus.rready, 0);
    check("t5_rst_last", dut.last_q, 2);
    clear_models();
    tick();
    tick();
    rst = 1'b0;
    push_req(0, 32'h800, 8'd0, -1);
    push_req(1, 32'h900, 8'd0, -1);
    push_ar(2'd0, 32'h800, 8'd0);
    push_ar(2'd1, 32'h900, 8'd0);
    drain("t5", 30);

    // 6: last=1, all three requesting -> 2,0,1,2; others wait through DATA
    push_req(2, 32'hA00, 8'd3, -1);
    push_req(2, 32'hA10, 8'd0, -1);
    push_req(0, 32'hB00, 8'd0, -1);
    push_req(1, 32'hC00, 8'd0, -1);
    push_ar(2'd2, 32'hA00, 8'd3);
    push_ar(2'd0, 32'hB00, 8'd0);
    push_ar(2'd1, 32'hC00, 8'd0);
    push_ar(2'd2, 32'hA10, 8'd0);
    drain("t6", 60);
    tick();
    check("t6_last", dut.last_q, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
